// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file block copier: default geometry and the copier state enum.
// The state enum is also intended for use by bench-side monitors.
package regfile_pkg;

   localparam int REGFILE_ADDR_W = 8;
   localparam int REGFILE_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COPY = 2'd1,
      FIN  = 2'd2
   } copier_state_t;

endpackage

// File: rtl/regfile_block_copier_if.sv
// Host request/status and register-file port bundle for regfile_block_copier.
// The Checksum signal exists only when COPY_CHECKSUM_EN is defined.
interface regfile_block_copier_if
   import regfile_pkg::*;
#(
   parameter int ADDR_W = REGFILE_ADDR_W,
   parameter int DATA_W = REGFILE_DATA_W
);

   logic              Start;
   logic [ADDR_W-1:0] Src_Addr;
   logic [ADDR_W-1:0] Dst_Addr;
   logic [ADDR_W-1:0] Len;
   logic              Busy;
   logic              Done;
   logic [ADDR_W-1:0] R_Addr;
   logic              R_en;
   logic [DATA_W-1:0] R_Data;
   logic [ADDR_W-1:0] W_Addr;
   logic              W_en;
   logic [DATA_W-1:0] W_Data;
`ifdef COPY_CHECKSUM_EN
   logic [DATA_W-1:0] Checksum;
`endif

   // master: host plus register file; slave: the copier itself.
`ifdef COPY_CHECKSUM_EN
   modport master (
      output Start, Src_Addr, Dst_Addr, Len, R_Data,
      input  Busy, Done, R_Addr, R_en, W_Addr, W_en, W_Data, Checksum
   );
   modport slave (
      input  Start, Src_Addr, Dst_Addr, Len, R_Data,
      output Busy, Done, R_Addr, R_en, W_Addr, W_en, W_Data, Checksum
   );
`else
   modport master (
      output Start, Src_Addr, Dst_Addr, Len, R_Data,
      input  Busy, Done, R_Addr, R_en, W_Addr, W_en, W_Data
   );
   modport slave (
      input  Start, Src_Addr, Dst_Addr, Len, R_Data,
      output Busy, Done, R_Addr, R_en, W_Addr, W_en, W_Data
   );
`endif

endinterface

// File: rtl/copy_index_counter.sv
// Transfer index for the block copier: loads the byte count, clears the index, counts up
// and flags the final transfer (index == count-1).
module copy_index_counter #(
   parameter int W = 8
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         load,
   input  logic         inc,
   input  logic [W-1:0] len,
   output logic [W-1:0] idx,
   output logic         last
);

   logic [W-1:0] len_q;

   // NOTE: synchronous reset -- Rst is only looked at on the rising clock edge.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         idx   <= '0;
         len_q <= '0;
      end else if (load) begin
         idx   <= '0;
         len_q <= len;
      end else if (inc) begin
         idx   <= idx + W'(1);
      end
   end

   assign last = (idx == len_q - W'(1));

endmodule

// File: rtl/regfile_block_copier.sv
// Copies Len bytes from Src_Addr.. to Dst_Addr.. of a 256x8 register file, one byte per cycle,
// in ascending order. Define COPY_CHECKSUM_EN to add a mod-2**DATA_W sum of the bytes written.
module regfile_block_copier
   import regfile_pkg::*;
#(
   parameter int ADDR_W = REGFILE_ADDR_W,
   parameter int DATA_W = REGFILE_DATA_W
) (
   input logic                   Clk,
   input logic                   Rst,
   regfile_block_copier_if.slave bus
);

   copier_state_t     state;
   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;
   logic [ADDR_W-1:0] idx;
   logic              last;
   logic              accept;

   assign accept = (state == IDLE) && bus.Start;

   copy_index_counter #(.W(ADDR_W)) u_copy_index_counter (
      .Clk  (Clk),
      .Rst  (Rst),
      .load (accept),
      .inc  (state == COPY),
      .len  (bus.Len),
      .idx  (idx),
      .last (last)
   );

   // NOTE: the read bus floats when R_en is low; gating on W_en keeps Z off the write port.
   assign bus.W_Data = bus.W_en ? bus.R_Data : {DATA_W{1'b0}};

   // NOTE: non-blocking assignments so every register updates from its pre-edge value.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state      <= IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         bus.Busy   <= 1'b0;
         bus.Done   <= 1'b0;
         bus.R_en   <= 1'b0;
         bus.W_en   <= 1'b0;
         bus.R_Addr <= '0;
         bus.W_Addr <= '0;
      end else begin
         bus.Done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.Start) begin
                  src_q    <= bus.Src_Addr;
                  dst_q    <= bus.Dst_Addr;
                  bus.Busy <= 1'b1;
                  if (bus.Len != '0) begin
                     state      <= COPY;
                     bus.R_en   <= 1'b1;
                     bus.W_en   <= 1'b1;
                     bus.R_Addr <= bus.Src_Addr;
                     bus.W_Addr <= bus.Dst_Addr;
                  end else begin
                     state    <= FIN;
                     bus.Done <= 1'b1;
                  end
               end
            end
            COPY: begin
               if (last) begin
                  state      <= FIN;
                  bus.Done   <= 1'b1;
                  bus.R_en   <= 1'b0;
                  bus.W_en   <= 1'b0;
                  bus.R_Addr <= '0;
                  bus.W_Addr <= '0;
               end else begin
                  // Address sums wrap naturally at the ADDR_W boundary.
                  bus.R_Addr <= src_q + idx + ADDR_W'(1);
                  bus.W_Addr <= dst_q + idx + ADDR_W'(1);
               end
            end
            FIN: begin
               state    <= IDLE;
               bus.Busy <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               bus.Busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef COPY_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q;

   // Cleared on accept, accumulates each written byte, then holds until the next accept.
   always_ff @(posedge Clk) begin
      if (Rst || accept) begin
         sum_q <= '0;
      end else if (bus.W_en) begin
         sum_q <= sum_q + bus.W_Data;
      end
   end

   assign bus.Checksum = sum_q;
`endif

endmodule
